// File: rtl/row_copy_engine.sv
// row_copy_engine
// Copies N consecutive 64-bit rows from a source banked memory's row read
// port into a destination memory's row write port, one row per cycle after a
// one-cycle fill that covers the source memory's read latency.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start, abort          command strobe (sampled in IDLE), copy termination
//   src_row, dst_row      first source/destination row, latched on start
//   row_count             rows to copy, latched on start
//   src_address           source word address {row, 2'b00}
//   src_row_data          source row data (word 0 at [63:48])
//   dst_address           destination word address {row, 2'b00}
//   dst_row_data          destination row data (word 0 at [15:0])
//   dst_row_write         destination row write strobe
//   busy, done            copy active, one-cycle completion pulse
module row_copy_engine #(
    parameter int ADDR_WIDTH  = 12,
    parameter int COUNT_WIDTH = 11
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-3:0]   src_row,
    input  logic [ADDR_WIDTH-3:0]   dst_row,
    input  logic [COUNT_WIDTH-1:0]  row_count,
    output logic [ADDR_WIDTH-1:0]   src_address,
    input  logic [63:0]             src_row_data,
    output logic [ADDR_WIDTH-1:0]   dst_address,
    output logic [63:0]             dst_row_data,
    output logic                    dst_row_write,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          src_ptr_q, src_ptr_d;
    logic [RW-1:0]          dst_ptr_q, dst_ptr_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   done_q, done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    src_ptr_d = src_row;
                    dst_ptr_d = dst_row;
                    cnt_d     = row_count;
                    if (row_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Read of the first row is in flight; present the next
                    // row so the stream phase keeps one read ahead.
                    state_d   = STREAM;
                    src_ptr_d = src_ptr_q + RW'(1);
                end
            end
            STREAM: begin
                if (abort) begin
                    // The write driven this cycle still lands; no done.
                    state_d = IDLE;
                end else begin
                    src_ptr_d = src_ptr_q + RW'(1);
                    dst_ptr_d = dst_ptr_q + RW'(1);
                    cnt_d     = cnt_q - COUNT_WIDTH'(1);
                    if (cnt_q == COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign dst_row_write = (state_q == STREAM);
    assign done          = done_q;
    assign src_address   = {src_ptr_q, 2'b00};
    assign dst_address   = {dst_ptr_q, 2'b00};

    // Lane reversal maps source word k onto destination word k, since the two
    // row ports number their words from opposite ends.
    assign dst_row_data = dst_row_write
                        ? {src_row_data[15:0],  src_row_data[31:16],
                           src_row_data[47:32], src_row_data[63:48]}
                        : '0;

endmodule

// File: tb/tb_row_copy_engine.sv
// Testbench for row_copy_engine: behavioural source memory with one-cycle read
// latency, a write log, and a reference model that derives the expected row
// writes from the copy parameters.
module tb_row_copy_engine;

    localparam int AW = 12;
    localparam int CW = 11;

    logic           clock;
    logic           reset;
    logic           start;
    logic           abort;
    logic [AW-3:0]  src_row;
    logic [AW-3:0]  dst_row;
    logic [CW-1:0]  row_count;
    logic [AW-1:0]  src_address;
    logic [63:0]    src_row_data;
    logic [AW-1:0]  dst_address;
    logic [63:0]    dst_row_data;
    logic           dst_row_write;
    logic           busy;
    logic           done;

    int checks;
    int errors;

    logic [63:0] src_mem [1024];
    logic [75:0] wlog [$];

    row_copy_engine #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .src_row       (src_row),
        .dst_row       (dst_row),
        .row_count     (row_count),
        .src_address   (src_address),
        .src_row_data  (src_row_data),
        .dst_address   (dst_address),
        .dst_row_data  (dst_row_data),
        .dst_row_write (dst_row_write),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        src_row_data <= src_mem[src_address[AW-1:2]];
        if (dst_row_write === 1'b1)
            wlog.push_back({dst_address, dst_row_data});
    end

    function automatic logic [63:0] rev(input logic [63:0] x);
        return {x[15:0], x[31:16], x[47:32], x[63:48]};
    endfunction

    function automatic logic [63:0] waddr(input int row);
        return 64'((row % 1024) * 4);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_wr"}, 64'(dst_row_write), 64'd0);
        chk({tag, "_data"}, dst_row_data, 64'd0);
    endtask

    // Runs one complete copy with per-cycle timing checks, then compares the
    // logged writes with the model's expected row sequence.
    task automatic run_copy(input int s, input int d, input int n, input bit interfere);
        logic [75:0] expq [$];
        for (int i = 0; i < n; i++)
            expq.push_back({waddr(d + i)[11:0], rev(src_mem[(s + i) % 1024])});
        wlog.delete();
        src_row   = 10'(s);
        dst_row   = 10'(d);
        row_count = 11'(n);
        start     = 1'b1;
        step();
        start     = 1'b0;
        src_row   = 10'($urandom);
        dst_row   = 10'($urandom);
        row_count = 11'($urandom_range(1, 9));
        for (int c = 1; c <= n + 1; c++) begin
            start = (interfere && c == 2) ? 1'b1 : 1'b0;
            chk("cp_busy", 64'(busy), 64'd1);
            chk("cp_done", 64'(done), 64'd0);
            chk("cp_wr", 64'(dst_row_write), (c >= 2) ? 64'd1 : 64'd0);
            chk("cp_src_addr", 64'(src_address), waddr(s + c - 1));
            if (c >= 2) begin
                chk("cp_dst_addr", 64'(dst_address), waddr(d + c - 2));
                chk("cp_dst_data", dst_row_data, rev(src_mem[(s + c - 2) % 1024]));
            end else begin
                chk("cp_fill_data", dst_row_data, 64'd0);
            end
            step();
        end
        start = 1'b0;
        chk("cp_done_pulse", 64'(done), 64'd1);
        chk_idle_outputs("cp_end");
        step();
        chk("cp_done_clear", 64'(done), 64'd0);
        chk("cp_nwrites", 64'(wlog.size()), 64'(n));
        for (int i = 0; i < n && i < wlog.size(); i++) begin
            chk("cp_log_addr", 64'(wlog[i][75:64]), 64'(expq[i][75:64]));
            chk("cp_log_data", wlog[i][63:0], expq[i][63:0]);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        src_row   = '0;
        dst_row   = '0;
        row_count = '0;
        for (int i = 0; i < 1024; i++)
            src_mem[i] = {$urandom, $urandom};
        src_mem[5] = 64'h1111_2222_3333_4444;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr", 64'(dst_row_write), 64'd0);
        chk("rst_src_addr", 64'(src_address), 64'd0);
        chk("rst_dst_addr", 64'(dst_address), 64'd0);
        chk("rst_data", dst_row_data, 64'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Single row with explicit values
        src_row = 10'd5; dst_row = 10'd9; row_count = 11'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("single_src_addr", 64'(src_address), 64'h014);
        step();
        chk("single_wr", 64'(dst_row_write), 64'd1);
        chk("single_dst_addr", 64'(dst_address), 64'h024);
        chk("single_data", dst_row_data, 64'h4444_3333_2222_1111);
        step();
        chk("single_done", 64'(done), 64'd1);
        chk_idle_outputs("single_end");
        step();

        // Burst, wrap, interference and random copies
        run_copy(0, 9, 4, 1'b0);
        run_copy(1023, 1023, 2, 1'b0);
        run_copy($urandom_range(0, 1023), $urandom_range(0, 1023), 5, 1'b1);
        for (int k = 0; k < 6; k++)
            run_copy($urandom_range(0, 1023), $urandom_range(1010, 1023),
                     $urandom_range(1, 16), 1'b0);

        // Zero count
        wlog.delete();
        src_row = 10'd3; dst_row = 10'd4; row_count = 11'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done", 64'(done), 64'd1);
        chk_idle_outputs("zero_t1");
        step();
        chk("zero_done_clear", 64'(done), 64'd0);
        chk("zero_busy2", 64'(busy), 64'd0);
        chk("zero_nwrites", 64'(wlog.size()), 64'd0);

        // start together with abort in IDLE is ignored
        src_row = 10'd1; row_count = 11'd4; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("startabort_busy", 64'(busy), 64'd0);
        chk("startabort_done", 64'(done), 64'd0);
        step();

        // Abort during the third write
        wlog.delete();
        src_row = 10'd100; dst_row = 10'd200; row_count = 11'd8; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        abort = 1'b1;
        chk("abort_wr_cycle", 64'(dst_row_write), 64'd1);
        chk("abort_wr_addr", 64'(dst_address), waddr(202));
        step();
        abort = 1'b0;
        chk_idle_outputs("abort_next");
        chk("abort_done", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_done", 64'(done), 64'd0);
        end
        chk("abort_nwrites", 64'(wlog.size()), 64'd3);

        // Asynchronous reset mid-copy
        wlog.delete();
        src_row = 10'd50; dst_row = 10'd60; row_count = 11'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #1 reset = 1'b1;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_wr", 64'(dst_row_write), 64'd0);
        chk("mrst_src_addr", 64'(src_address), 64'd0);
        chk("mrst_dst_addr", 64'(dst_address), 64'd0);
        chk("mrst_data", dst_row_data, 64'd0);
        chk("mrst_nwrites_pre", 64'(wlog.size()), 64'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("mrst_no_done", 64'(done), 64'd0);
        end
        chk("mrst_busy_after", 64'(busy), 64'd0);
        chk("mrst_nwrites", 64'(wlog.size()), 64'd1);

        // Engine still works after the reset
        run_copy(1020, 3, 7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
